// File: rtl/branch_predictor_ctrl_pkg.sv
// Shared types for the branch predictor sequencer: FSM states, 2-bit counter
// encodings and the saturating counter update.
package branch_predictor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LK_RD  = 2'd1,
    UPD_RD = 2'd2,
    UPD_WR = 2'd3
  } bp_state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_ctrl_if.sv
// Fetch-lookup and execute-resolution channels of the branch predictor sequencer.
interface branch_predictor_ctrl_if #(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 16
);
  // Both request channels transfer on a cycle where valid && ready; the master
  // holds valid and payload stable until then. lk_resp_valid is a 1-cycle pulse.
  logic              lk_valid;
  logic [IDX_W-1:0]  lk_pc;
  logic              lk_ready;
  logic              lk_resp_valid;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_ready;

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  lk_ready, lk_resp_valid, lk_taken, lk_target, upd_ready
  );

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output lk_ready, lk_resp_valid, lk_taken, lk_target, upd_ready
  );
endinterface

// File: rtl/branch_predictor_ctrl_upd_fifo.sv
// Pending branch-resolution FIFO; entries are packed {pc, taken, target}.
module bp_upd_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/branch_predictor_ctrl.sv
// Sequencer sharing the BTA/prediction table index between fetch lookups and
// queued execute-stage resolutions (read-modify-write of the 2-bit counter).
module branch_predictor_ctrl
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int IDX_W      = 2,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  branch_predictor_ctrl_if.slave   bus,
  output logic [IDX_W-1:0]         tbl_idx,
  output logic                     tbl_bta_wr,
  output logic [ADDR_W-1:0]        tbl_new_bta,
  output logic                     tbl_pred_wr,
  output logic [1:0]               tbl_new_pred,
  input  logic [ADDR_W-1:0]        tbl_bta_rd,
  input  logic [1:0]               tbl_pred_rd,
  output bp_state_t                dbg_state
);
  localparam int ENT_W = IDX_W + 1 + ADDR_W;

  bp_state_t         state;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  head;
  logic [IDX_W-1:0]  head_pc;
  logic              head_taken;
  logic [ADDR_W-1:0] head_target;

  assign {head_pc, head_taken, head_target} = head;
  assign push          = bus.upd_valid && !full;
  assign pop           = (state == UPD_WR);
  assign bus.upd_ready = !full;
  assign bus.lk_ready  = (state == IDLE) && !full;
  assign dbg_state     = state;

  bp_upd_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({bus.upd_pc, bus.upd_taken, bus.upd_target}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tbl_idx           <= '0;
      tbl_bta_wr        <= 1'b0;
      tbl_new_bta       <= '0;
      tbl_pred_wr       <= 1'b0;
      tbl_new_pred      <= '0;
      bus.lk_resp_valid <= 1'b0;
      bus.lk_taken      <= 1'b0;
      bus.lk_target     <= '0;
    end else begin
      bus.lk_resp_valid <= 1'b0;
      tbl_pred_wr       <= 1'b0;
      tbl_bta_wr        <= 1'b0;
      case (state)
        // A full FIFO would stall execute, so it outranks fetch.
        IDLE: begin
          if (full) begin
            state   <= UPD_RD;
            tbl_idx <= head_pc;
          end else if (bus.lk_valid) begin
            state   <= LK_RD;
            tbl_idx <= bus.lk_pc;
          end else if (!empty) begin
            state   <= UPD_RD;
            tbl_idx <= head_pc;
          end
        end
        LK_RD: begin
          bus.lk_resp_valid <= 1'b1;
          bus.lk_taken      <= tbl_pred_rd[1];
          bus.lk_target     <= tbl_bta_rd;
          state             <= IDLE;
        end
        UPD_RD: begin
          tbl_pred_wr  <= 1'b1;
          tbl_new_pred <= sat_update(tbl_pred_rd, head_taken);
          tbl_bta_wr   <= head_taken;
          tbl_new_bta  <= head_target;
          state        <= UPD_WR;
        end
        UPD_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Bench for branch_predictor_ctrl: behavioural table model plus scoreboard,
// directed scenarios followed by randomized lookup/resolution traffic.
module tb_branch_predictor_ctrl;
  import branch_predictor_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clear = 1'b1;

  branch_predictor_ctrl_if #(.IDX_W(2), .ADDR_W(16)) bus ();

  logic [1:0]  tbl_idx;
  logic        tbl_bta_wr;
  logic [15:0] tbl_new_bta;
  logic        tbl_pred_wr;
  logic [1:0]  tbl_new_pred;
  logic [15:0] tbl_bta_rd;
  logic [1:0]  tbl_pred_rd;
  bp_state_t   dbg_state;

  branch_predictor_ctrl #(.IDX_W(2), .ADDR_W(16), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .tbl_idx      (tbl_idx),
    .tbl_bta_wr   (tbl_bta_wr),
    .tbl_new_bta  (tbl_new_bta),
    .tbl_pred_wr  (tbl_pred_wr),
    .tbl_new_pred (tbl_new_pred),
    .tbl_bta_rd   (tbl_bta_rd),
    .tbl_pred_rd  (tbl_pred_rd),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // table datapath stand-in: decoder + mux + storage
  logic [15:0] bta_mem [4];
  logic [1:0]  pred_mem [4];
  assign tbl_bta_rd  = bta_mem[tbl_idx];
  assign tbl_pred_rd = pred_mem[tbl_idx];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4; i++) begin
        bta_mem[i]  <= '0;
        pred_mem[i] <= '0;
      end
    end else begin
      if (tbl_pred_wr) pred_mem[tbl_idx] <= tbl_new_pred;
      if (tbl_bta_wr)  bta_mem[tbl_idx]  <= tbl_new_bta;
    end
  end

  // checking
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // scoreboard and reference model
  logic [18:0] exp_q [$];
  logic [1:0]  lk_pc_q [$];
  int          lk_cyc_q [$];
  int          m_pred [4];
  logic [15:0] m_bta [4];
  int          n_wr = 0;
  int          n_resp = 0;
  bit          saw_full = 1'b0;
  logic        last_taken;
  logic [15:0] last_target;

  logic [18:0] e;
  logic [1:0]  e_pc;
  logic        e_tk;
  logic [15:0] e_tg;
  int          np;
  int          acc;

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4; i++) begin
        m_pred[i] = 0;
        m_bta[i]  = '0;
      end
    end
    if (reset) begin
      exp_q.delete();
      lk_pc_q.delete();
      lk_cyc_q.delete();
    end else begin
      if (tbl_bta_wr && !tbl_pred_wr) check("bta_wr_alone", 1, 0);
      if (tbl_pred_wr) begin
        n_wr++;
        if (exp_q.size() == 0) check("spurious_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          {e_pc, e_tk, e_tg} = e;
          np = e_tk ? ((m_pred[e_pc] < 3) ? m_pred[e_pc] + 1 : 3)
                    : ((m_pred[e_pc] > 0) ? m_pred[e_pc] - 1 : 0);
          check("wr_idx", tbl_idx, e_pc);
          check("wr_pred", tbl_new_pred, np);
          check("wr_bta_en", tbl_bta_wr, e_tk);
          if (e_tk) check("wr_bta", tbl_new_bta, e_tg);
          m_pred[e_pc] = np;
          if (e_tk) m_bta[e_pc] = e_tg;
        end
      end
      if (bus.lk_resp_valid) begin
        n_resp++;
        last_taken  = bus.lk_taken;
        last_target = bus.lk_target;
        if (lk_pc_q.size() == 0) check("resp_unexp", 1, 0);
        else begin
          e_pc = lk_pc_q.pop_front();
          acc  = lk_cyc_q.pop_front();
          check("lk_latency", cyc - acc, 2);
          check("lk_taken", bus.lk_taken, (m_pred[e_pc] >= 2) ? 1 : 0);
          check("lk_target", bus.lk_target, m_bta[e_pc]);
        end
      end
      if (bus.lk_valid && bus.lk_ready) begin
        lk_pc_q.push_back(bus.lk_pc);
        lk_cyc_q.push_back(cyc);
      end
      if (bus.upd_valid && bus.upd_ready)
        exp_q.push_back({bus.upd_pc, bus.upd_taken, bus.upd_target});
      if (!bus.upd_ready) begin
        saw_full = 1'b1;
        check("full_blocks_lk", bus.lk_ready, 0);
      end
    end
  end

  // driver tasks
  task automatic do_update(input logic [1:0] pc, input logic tk, input logic [15:0] tg);
    bit ok = 1'b0;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tg;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.upd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
    if (!ok) check("upd_timeout", 0, 1);
  endtask

  task automatic do_lookup(input logic [1:0] pc);
    bit ok = 1'b0;
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.lk_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 bus.lk_valid = 1'b0;
    if (!ok) check("lk_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && lk_pc_q.size() == 0 && !bus.upd_valid && !bus.lk_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int          wr_before;
  logic [1:0]  snap_pred;
  logic [15:0] snap_bta;
  bit          lk_fire;
  bit          up_fire;

  initial begin
    bus.lk_valid   = 1'b0;
    bus.lk_pc      = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mem_clear = 1'b0;

    @(negedge clk);
    check("rst_resp_valid", bus.lk_resp_valid, 0);
    check("rst_taken", bus.lk_taken, 0);
    check("rst_target", bus.lk_target, 0);
    check("rst_idx", tbl_idx, 0);
    check("rst_pred_wr", tbl_pred_wr, 0);
    check("rst_bta_wr", tbl_bta_wr, 0);
    check("rst_new_pred", tbl_new_pred, 0);
    check("rst_new_bta", tbl_new_bta, 0);
    check("rst_lk_ready", bus.lk_ready, 1);
    check("rst_upd_ready", bus.upd_ready, 1);
    @(posedge clk);
    #1;

    // lookup on a cleared table
    do_lookup(2'd3);
    drain();
    check("t1_resp_cnt", n_resp, 1);
    check("t1_taken", last_taken, 0);
    check("t1_target", last_target, 0);

    // taken resolution then lookup
    do_update(2'd3, 1'b1, 16'd9);
    drain();
    check("t2_pred_mem", pred_mem[3], 1);
    do_lookup(2'd3);
    drain();
    check("t2_taken", last_taken, 0);
    check("t2_target", last_target, 9);
    do_update(2'd3, 1'b1, 16'd9);
    drain();
    do_lookup(2'd3);
    drain();
    check("t2_pred2", pred_mem[3], 2);
    check("t2_taken2", last_taken, 1);

    // saturation both ways; not-taken leaves BTA alone
    for (int i = 0; i < 4; i++) do_update(2'd2, 1'b1, 16'd16);
    drain();
    check("t3_sat_hi", pred_mem[2], 3);
    for (int i = 0; i < 4; i++) do_update(2'd2, 1'b0, 16'($urandom_range(17, 65535)));
    drain();
    check("t3_sat_lo", pred_mem[2], 0);
    check("t3_bta_kept", bta_mem[2], 16);
    do_lookup(2'd2);
    drain();
    check("t3_lk_target", last_target, 16);

    // back-to-back updates against a persistent lookup
    saw_full  = 1'b0;
    wr_before = n_wr;
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 2'd1;
    do_update(2'd0, 1'b1, 16'h0a0a);
    do_update(2'd1, 1'b1, 16'h0b0b);
    do_update(2'd2, 1'b0, 16'h0c0c);
    repeat (4) @(posedge clk);
    #1 bus.lk_valid = 1'b0;
    drain();
    check("t4_full_seen", saw_full, 1);
    check("t4_writes", n_wr - wr_before, 3);

    // push coinciding with pop keeps one entry in flight across pointer wrap
    saw_full  = 1'b0;
    wr_before = n_wr;
    do_update(2'd1, 1'b1, 16'h1111);
    repeat (2) @(posedge clk);
    #1 do_update(2'd2, 1'b1, 16'h2222);
    repeat (2) @(posedge clk);
    #1 do_update(2'd3, 1'b0, 16'h3333);
    repeat (2) @(posedge clk);
    #1 do_update(2'd0, 1'b1, 16'h4444);
    drain();
    check("t5_never_full", saw_full, 0);
    check("t5_writes", n_wr - wr_before, 4);
    check("t5_bta1", bta_mem[1], 16'h1111);
    check("t5_bta0", bta_mem[0], 16'h4444);

    // reset while the read half of an RMW is in progress
    snap_pred = pred_mem[1];
    snap_bta  = bta_mem[1];
    wr_before = n_wr;
    do_update(2'd1, ~pred_mem[1][1], 16'h5a5a);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_write", n_wr - wr_before, 0);
    check("t6_pred_kept", pred_mem[1], snap_pred);
    check("t6_bta_kept", bta_mem[1], snap_bta);
    check("t6_upd_ready", bus.upd_ready, 1);
    check("t6_lk_ready", bus.lk_ready, 1);
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      lk_fire = bus.lk_valid && bus.lk_ready;
      up_fire = bus.upd_valid && bus.upd_ready;
      @(posedge clk);
      #1;
      if (!bus.lk_valid || lk_fire) begin
        bus.lk_valid = ($urandom_range(0, 2) == 0);
        bus.lk_pc    = 2'($urandom_range(0, 3));
      end
      if (!bus.upd_valid || up_fire) begin
        bus.upd_valid  = ($urandom_range(0, 2) == 0);
        bus.upd_pc     = 2'($urandom_range(0, 3));
        bus.upd_taken  = 1'($urandom_range(0, 1));
        bus.upd_target = 16'($urandom);
      end
    end
    bus.lk_valid  = 1'b0;
    bus.upd_valid = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) begin
      check("final_pred", pred_mem[i], m_pred[i]);
      check("final_bta", bta_mem[i], m_bta[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=%0d expected=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
